orion_sim_ctrl: RTL and testbench

Simulation run controller placed between the GUI host and `orion_pro_top`, generalising the fixed turbo flag and hard-wired configuration switches. Generates a programmable core clock-enable divider, a timed core reset sequence, runtime config-switch updates via valid/ready handshake, and run/pause/single-step control with a core-cycle counter. All core-facing signals are driven from registers.

---
 rtl/orion_sim_pkg.sv | 13 +
 rtl/orion_ce_div.sv | 41 ++++
 rtl/orion_sim_ctrl.sv | 137 +++++++++++++
 tb/tb_orion_sim_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_sim_pkg.sv
// rtl/orion_sim_pkg.sv - shared state encoding and default switch value for the sim run controller
package orion_sim_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } sim_state_t;

  localparam logic [7:0] SW_DEFAULT = 8'b0000_1001;

endpackage

// File: rtl/orion_ce_div.sv
// rtl/orion_ce_div.sv - programmable core clock-enable divider, period i_div+1 clocks
module orion_ce_div #(
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_restart,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ce
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  // The period is captured only at restart and at each enable boundary, so a
  // divider change never shortens the period already in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt    <= '0;
      period <= '0;
      o_ce   <= 1'b0;
    end else if (i_restart) begin
      cnt    <= '0;
      period <= i_div;
      o_ce   <= 1'b0;
    end else if (i_en) begin
      if (cnt == period) begin
        cnt    <= '0;
        period <= i_div;
        o_ce   <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        o_ce <= 1'b0;
      end
    end else begin
      o_ce <= 1'b0;
    end
  end

endmodule

// File: rtl/orion_sim_ctrl.sv
// rtl/orion_sim_ctrl.sv - run/pause/step controller with timed core reset and config-switch handshake
module orion_sim_ctrl #(
  parameter int                SW_W       = 8,
  parameter logic [SW_W-1:0]   SW_DEFAULT = orion_sim_pkg::SW_DEFAULT,
  parameter int                DIV_W      = 4,
  parameter int                RST_CYCLES = 16,
  parameter int                CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [SW_W-1:0]  i_cfg_sw,
  input  logic [DIV_W-1:0] i_turbo_div,
  input  logic             i_run,
  input  logic             i_step_valid,
  input  logic [CNT_W-1:0] i_step_count,
  output logic             o_step_done,
  output logic             o_core_ce,
  output logic             o_core_reset_n,
  output logic [SW_W-1:0]  o_cfg_sw,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [1:0]       o_state
);

  import orion_sim_pkg::*;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  sim_state_t       state;
  sim_state_t       state_nxt;
  logic [RCW-1:0]   rst_cnt;
  logic [CNT_W-1:0] step_left;
  logic             cfg_xfer;
  logic             rst_done;
  logic             step_last;
  logic             div_restart;
  logic             div_en;
  logic             reset_n_nxt;
  logic             done_nxt;

  assign cfg_xfer  = i_cfg_valid && (state != ST_RESET);
  assign rst_done  = (rst_cnt == RCW'(RST_CYCLES - 1));
  // The step ends either immediately for a zero count or on its final enable.
  assign step_last = (step_left == '0) || (o_core_ce && (step_left == CNT_W'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: begin
        if (rst_done) state_nxt = i_run ? ST_RUN : ST_PAUSE;
      end
      ST_RUN: begin
        if (cfg_xfer)    state_nxt = ST_RESET;
        else if (!i_run) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (cfg_xfer)          state_nxt = ST_RESET;
        else if (i_step_valid) state_nxt = ST_STEP;
        else if (i_run)        state_nxt = ST_RUN;
      end
      ST_STEP: begin
        if (cfg_xfer)       state_nxt = ST_RESET;
        else if (step_last) state_nxt = ST_PAUSE;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // Enables are only allowed while staying in RUN/STEP, so a departing
  // transition can never leave a stray enable behind in PAUSE or RESET.
  always_comb begin
    div_restart = 1'b0;
    div_en      = 1'b0;
    reset_n_nxt = 1'b0;
    done_nxt    = 1'b0;
    div_restart = ((state_nxt == ST_RUN)  && (state != ST_RUN)) ||
                  ((state_nxt == ST_STEP) && (state != ST_STEP));
    div_en      = ((state == ST_RUN)  && (state_nxt == ST_RUN)) ||
                  ((state == ST_STEP) && (state_nxt == ST_STEP));
    reset_n_nxt = (state_nxt != ST_RESET);
    done_nxt    = (state == ST_STEP) && (state_nxt == ST_PAUSE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rst_cnt        <= '0;
      step_left      <= '0;
      o_cfg_sw       <= SW_DEFAULT;
      o_cycle_cnt    <= '0;
      o_step_done    <= 1'b0;
      o_core_reset_n <= 1'b0;
    end else begin
      o_core_reset_n <= reset_n_nxt;
      o_step_done    <= done_nxt;

      if ((state == ST_RESET) && (state_nxt == ST_RESET)) rst_cnt <= rst_cnt + 1'b1;
      else                                                 rst_cnt <= '0;

      if (cfg_xfer) o_cfg_sw <= i_cfg_sw;

      if (state_nxt == ST_RESET) begin
        step_left <= '0;
      end else if ((state == ST_PAUSE) && (state_nxt == ST_STEP)) begin
        step_left <= i_step_count;
      end else if ((state == ST_STEP) && o_core_ce && (step_left != '0)) begin
        step_left <= step_left - 1'b1;
      end

      if (state_nxt == ST_RESET) o_cycle_cnt <= '0;
      else if (o_core_ce)        o_cycle_cnt <= o_cycle_cnt + 1'b1;
    end
  end

  orion_ce_div #(
    .DIV_W (DIV_W)
  ) u_ce_div (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (div_restart),
    .i_en      (div_en),
    .i_div     (i_turbo_div),
    .o_ce      (o_core_ce)
  );

  assign o_cfg_ready = (state != ST_RESET);
  assign o_state     = state;

endmodule

// File: tb/tb_orion_sim_ctrl.sv
// tb/tb_orion_sim_ctrl.sv - self-checking bench for orion_sim_ctrl
module tb_orion_sim_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [7:0]  i_cfg_sw;
  logic [3:0]  i_turbo_div;
  logic        i_run;
  logic        i_step_valid;
  logic [31:0] i_step_count;
  logic        o_step_done;
  logic        o_core_ce;
  logic        o_core_reset_n;
  logic [7:0]  o_cfg_sw;
  logic [31:0] o_cycle_cnt;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  orion_sim_ctrl dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_sw       (i_cfg_sw),
    .i_turbo_div    (i_turbo_div),
    .i_run          (i_run),
    .i_step_valid   (i_step_valid),
    .i_step_count   (i_step_count),
    .o_step_done    (o_step_done),
    .o_core_ce      (o_core_ce),
    .o_core_reset_n (o_core_reset_n),
    .o_cfg_sw       (o_cfg_sw),
    .o_cycle_cnt    (o_cycle_cnt),
    .o_state        (o_state)
  );

  typedef struct {
    logic [31:0] count;
    logic [3:0]  div;
    int          period;
    int          done_off;
  } step_vec_t;

  step_vec_t vecs[4];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int pulses_prior = 0;
  bit sb_on    = 1'b0;
  int exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; samples 1ns after the edge and feeds the enable scoreboard.
  task automatic cycle();
    int e;
    @(posedge i_clk);
    #1;
    cyc++;
    pulses_prior = pulses;
    if (o_core_ce) pulses++;
    if (sb_on && o_core_ce) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb_unexpected_ce: enable at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ce_cycle", cyc, e);
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", o_state, 0);
    chk("rst_core_n", o_core_reset_n, 0);
    chk("rst_ce", o_core_ce, 0);
    chk("rst_cfg_sw", o_cfg_sw, 8'b0000_1001);
    chk("rst_cnt", o_cycle_cnt, 0);
    chk("rst_done", o_step_done, 0);
    chk("rst_ready", o_cfg_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int s;
    bit found;
    vecs[0] = '{count: 32'd5, div: 4'd2, period: 3, done_off: 16};
    vecs[1] = '{count: 32'd0, div: 4'd0, period: 1, done_off: 1};
    vecs[2] = '{count: 32'd3, div: 4'd0, period: 1, done_off: 4};
    vecs[3] = '{count: 32'd2, div: 4'd1, period: 2, done_off: 5};

    i_reset = 1'b1; i_cfg_valid = 1'b0; i_cfg_sw = 8'h00; i_turbo_div = 4'd0;
    i_run = 1'b1; i_step_valid = 1'b0; i_step_count = 32'd0;
    cycle(); cycle();
    chk_reset_vals();
    i_reset = 1'b0;
    pulses = 0;

    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("rst_hold_n", o_core_reset_n, 0);
      chk("rst_hold_ready", o_cfg_ready, 0);
    end
    cycle();
    chk("rst_release_n", o_core_reset_n, 1);
    chk("run_state", o_state, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("run_div0_ce", o_core_ce, 1);
    end
    cycle();
    chk("run_cnt10", o_cycle_cnt, 10);

    // Divider change mid-period: 4-clock period finishes, then 2-clock periods.
    i_turbo_div = 4'd3;
    repeat (3) cycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (o_core_ce) found = 1'b1;
    end
    chk("div3_sync", found, 1);
    f = cyc;
    exp_q.push_back(f + 4);
    exp_q.push_back(f + 6);
    exp_q.push_back(f + 8);
    sb_on = 1'b1;
    cycle();
    i_turbo_div = 4'd1;
    while (cyc < f + 8) cycle();
    sb_on = 1'b0;
    chk("div_sb_drain", exp_q.size(), 0);
    chk("run_cnt_track", o_cycle_cnt, pulses_prior);

    i_run = 1'b0;
    cycle();
    chk("pause_state", o_state, 2);
    chk("pause_ce", o_core_ce, 0);
    cycle();
    chk("pause_ce2", o_core_ce, 0);
    chk("pause_cnt", o_cycle_cnt, pulses_prior);

    sb_on = 1'b1;
    foreach (vecs[v]) begin
      i_turbo_div  = vecs[v].div;
      i_step_count = vecs[v].count;
      i_step_valid = 1'b1;
      cycle();
      i_step_valid = 1'b0;
      s = cyc;
      chk("step_enter", o_state, 3);
      for (int k = 1; k <= int'(vecs[v].count); k++) exp_q.push_back(s + k * vecs[v].period);
      for (int t = 1; t <= vecs[v].done_off; t++) begin
        cycle();
        chk("step_done", o_step_done, (t == vecs[v].done_off));
      end
      chk("step_pause", o_state, 2);
      chk("step_drain", exp_q.size(), 0);
      chk("step_cnt", o_cycle_cnt, pulses_prior);
      cycle();
      chk("step_done_pulse", o_step_done, 0);
    end
    sb_on = 1'b0;

    i_run = 1'b1;
    cycle();
    chk("resume_run", o_state, 1);
    repeat (3) cycle();
    chk("ready_run", o_cfg_ready, 1);
    i_cfg_valid = 1'b1;
    i_cfg_sw    = 8'hA5;
    cycle();
    i_cfg_valid = 1'b0;
    pulses = 0;
    chk("cfg_sw", o_cfg_sw, 8'hA5);
    chk("cfg_core_n", o_core_reset_n, 0);
    chk("cfg_state", o_state, 0);
    chk("cfg_cnt", o_cycle_cnt, 0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("cfg_hold_n", o_core_reset_n, 0);
      chk("cfg_hold_ready", o_cfg_ready, 0);
      chk("cfg_hold_cnt", o_cycle_cnt, 0);
      chk("cfg_hold_ce", o_core_ce, 0);
    end
    cycle();
    chk("cfg_release_n", o_core_reset_n, 1);
    chk("cfg_resume_run", o_state, 1);

    // Config transfer and step request together: config wins.
    i_run = 1'b0;
    cycle();
    chk("pause2_state", o_state, 2);
    sb_on = 1'b1;
    i_cfg_valid  = 1'b1;
    i_cfg_sw     = 8'h3C;
    i_step_valid = 1'b1;
    i_step_count = 32'd5;
    cycle();
    i_cfg_valid  = 1'b0;
    i_step_valid = 1'b0;
    pulses = 0;
    chk("race_state", o_state, 0);
    chk("race_cfg_sw", o_cfg_sw, 8'h3C);
    chk("race_core_n", o_core_reset_n, 0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("race_no_done", o_step_done, 0);
    end
    chk("race_pause", o_state, 2);

    // Reset mid-step after 3 of 5 enables.
    i_turbo_div  = 4'd0;
    i_step_count = 32'd5;
    i_step_valid = 1'b1;
    cycle();
    i_step_valid = 1'b0;
    s = cyc;
    exp_q.push_back(s + 1);
    exp_q.push_back(s + 2);
    exp_q.push_back(s + 3);
    repeat (3) cycle();
    i_reset = 1'b1;
    cycle();
    i_reset = 1'b0;
    pulses = 0;
    chk_reset_vals();
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("midstep_no_done", o_step_done, 0);
    end
    chk("midstep_drain", exp_q.size(), 0);
    chk("midstep_pause", o_state, 2);
    chk("midstep_cnt", o_cycle_cnt, 0);
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
